// File: rtl/pipeline_fetch_stage.sv
// IF stage and IF/ID pipeline register of the 5-stage RV32I pipeline.
// Holds the fetch PC, presents it to instruction memory, and latches the
// returned word into IF/ID under control of hazard stall/flush and EX-stage
// branch redirects. Two saturating counters track accepted instructions and
// bubble cycles for debug and CPI measurement.
module pipeline_fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_f,
  input  logic             flush_d,
  input  logic             branch_taken_e,
  input  logic [XLEN-1:0]  branch_target_e,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [XLEN-1:0]  pc_f,
  output logic [31:0]      instr_d,
  output logic [XLEN-1:0]  pc_d,
  output logic [XLEN-1:0]  pc_plus4_d,
  output logic             valid_d,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] bubble_count
);

  localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(32'd4);
  localparam logic [XLEN-1:0]  PC_ZERO  = {XLEN{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [XLEN-1:0]  pc_r;
  logic [31:0]      instr_r;
  logic [XLEN-1:0]  pc_d_r;
  logic [XLEN-1:0]  pc_plus4_r;
  logic             valid_r;
  logic [CNT_W-1:0] fetch_cnt_r;
  logic [CNT_W-1:0] bubble_cnt_r;

  logic             flush_int_s;
  logic             load_s;
  logic [XLEN-1:0]  pc_seq_s;
  logic [XLEN-1:0]  pc_nxt_s;
  logic [31:0]      instr_nxt_s;
  logic [XLEN-1:0]  pc_d_nxt_s;
  logic [XLEN-1:0]  pc_plus4_nxt_s;
  logic             valid_nxt_s;
  logic [CNT_W-1:0] fetch_cnt_nxt_s;
  logic [CNT_W-1:0] bubble_cnt_nxt_s;

  // A taken branch squashes the wrong-path word sitting in IF/ID, same as a hazard flush.
  assign flush_int_s = flush_d | branch_taken_e;
  // Sequential PC wraps modulo 2^XLEN by construction.
  assign pc_seq_s    = pc_r + PC_STEP;

  // Next fetch PC: redirect beats stall, stall beats sequential advance.
  always_comb begin
    pc_nxt_s = pc_seq_s;
    if (branch_taken_e) begin
      pc_nxt_s = {branch_target_e[XLEN-1:2], 2'b00};
    end else if (stall_f) begin
      pc_nxt_s = pc_r;
    end else begin
      pc_nxt_s = pc_seq_s;
    end
  end

  // Next IF/ID contents: flush inserts a bubble, stall holds, otherwise load the fetched word.
  always_comb begin
    instr_nxt_s    = instr_r;
    pc_d_nxt_s     = pc_d_r;
    pc_plus4_nxt_s = pc_plus4_r;
    valid_nxt_s    = valid_r;
    load_s         = 1'b0;
    if (flush_int_s) begin
      instr_nxt_s = NOP_INSTR;
      valid_nxt_s = 1'b0;
    end else if (stall_f) begin
      valid_nxt_s = valid_r;
    end else begin
      instr_nxt_s    = imem_rdata;
      pc_d_nxt_s     = pc_r;
      pc_plus4_nxt_s = pc_seq_s;
      valid_nxt_s    = 1'b1;
      load_s         = 1'b1;
    end
  end

  // Saturating performance counters: loads versus stall/flush bubble cycles.
  always_comb begin
    fetch_cnt_nxt_s  = fetch_cnt_r;
    bubble_cnt_nxt_s = bubble_cnt_r;
    if (load_s && (fetch_cnt_r != CNT_MAX)) begin
      fetch_cnt_nxt_s = fetch_cnt_r + CNT_ONE;
    end else begin
      fetch_cnt_nxt_s = fetch_cnt_r;
    end
    if ((stall_f || flush_int_s) && (bubble_cnt_r != CNT_MAX)) begin
      bubble_cnt_nxt_s = bubble_cnt_r + CNT_ONE;
    end else begin
      bubble_cnt_nxt_s = bubble_cnt_r;
    end
  end

  // State register with synchronous active-low reset overriding every other input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_r         <= RESET_PC;
      instr_r      <= NOP_INSTR;
      pc_d_r       <= PC_ZERO;
      pc_plus4_r   <= PC_ZERO;
      valid_r      <= 1'b0;
      fetch_cnt_r  <= CNT_ZERO;
      bubble_cnt_r <= CNT_ZERO;
    end else begin
      pc_r         <= pc_nxt_s;
      instr_r      <= instr_nxt_s;
      pc_d_r       <= pc_d_nxt_s;
      pc_plus4_r   <= pc_plus4_nxt_s;
      valid_r      <= valid_nxt_s;
      fetch_cnt_r  <= fetch_cnt_nxt_s;
      bubble_cnt_r <= bubble_cnt_nxt_s;
    end
  end

  assign imem_addr    = pc_r;
  assign pc_f         = pc_r;
  assign instr_d      = instr_r;
  assign pc_d         = pc_d_r;
  assign pc_plus4_d   = pc_plus4_r;
  assign valid_d      = valid_r;
  assign fetch_count  = fetch_cnt_r;
  assign bubble_count = bubble_cnt_r;

endmodule

// File: tb/tb_pipeline_fetch_stage.sv
// Scoreboard bench for pipeline_fetch_stage. Two instances share stimulus:
// one with default parameters, one with RESET_PC=0xFFFFFFF8 and 4-bit
// counters for PC wrap and counter saturation. The driver advances a
// behavioural model per edge and queues the expected state; a monitor pops
// and compares after every rising edge.
module tb_pipeline_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall_f;
  logic        flush_d;
  logic        branch_taken_e;
  logic [31:0] branch_target_e;

  logic [31:0] imem_addr_a, imem_rdata_a, pc_f_a, instr_d_a, pc_d_a, pc_plus4_d_a;
  logic        valid_d_a;
  logic [15:0] fetch_count_a, bubble_count_a;

  logic [31:0] imem_addr_b, imem_rdata_b, pc_f_b, instr_d_b, pc_d_b, pc_plus4_d_b;
  logic        valid_d_b;
  logic [3:0]  fetch_count_b, bubble_count_b;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pcp4;
    logic        valid;
    int          fc;
    int          bc;
  } ms_t;

  ms_t qa[$];
  ms_t qb[$];
  ms_t sa;
  ms_t sb;

  int checks;
  int failures;

  // Address-tagged instruction memory contents.
  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign imem_rdata_a = tag(imem_addr_a);
  assign imem_rdata_b = tag(imem_addr_b);

  pipeline_fetch_stage dut_a (
    .clk(clk), .reset(reset), .stall_f(stall_f), .flush_d(flush_d),
    .branch_taken_e(branch_taken_e), .branch_target_e(branch_target_e),
    .imem_addr(imem_addr_a), .imem_rdata(imem_rdata_a), .pc_f(pc_f_a),
    .instr_d(instr_d_a), .pc_d(pc_d_a), .pc_plus4_d(pc_plus4_d_a),
    .valid_d(valid_d_a), .fetch_count(fetch_count_a), .bubble_count(bubble_count_a)
  );

  pipeline_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .stall_f(stall_f), .flush_d(flush_d),
    .branch_taken_e(branch_taken_e), .branch_target_e(branch_target_e),
    .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b), .pc_f(pc_f_b),
    .instr_d(instr_d_b), .pc_d(pc_d_b), .pc_plus4_d(pc_plus4_d_b),
    .valid_d(valid_d_b), .fetch_count(fetch_count_b), .bubble_count(bubble_count_b)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Reference model: architectural effect of one clock edge.
  function automatic ms_t step(input ms_t s, input logic rst, input logic st, input logic fd,
                               input logic br, input logic [31:0] tgt,
                               input logic [31:0] rpc, input int cmax);
    ms_t n;
    logic fl;
    n = s;
    if (!rst) begin
      n.pc = rpc; n.instr = 32'h0000_0013; n.pcd = 32'h0; n.pcp4 = 32'h0;
      n.valid = 1'b0; n.fc = 0; n.bc = 0;
      return n;
    end
    fl = fd | br;
    if (br)       n.pc = tgt & 32'hFFFF_FFFC;
    else if (st)  n.pc = s.pc;
    else          n.pc = s.pc + 32'd4;
    if (fl) begin
      n.instr = 32'h0000_0013;
      n.valid = 1'b0;
    end else if (!st) begin
      n.instr = tag(s.pc);
      n.pcd   = s.pc;
      n.pcp4  = s.pc + 32'd4;
      n.valid = 1'b1;
      n.fc    = (s.fc < cmax) ? s.fc + 1 : cmax;
    end
    if (st || fl) n.bc = (s.bc < cmax) ? s.bc + 1 : cmax;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the expected post-edge state.
  task automatic cycle(input logic r, input logic s, input logic f, input logic b,
                       input logic [31:0] t);
    @(negedge clk);
    reset = r; stall_f = s; flush_d = f; branch_taken_e = b; branch_target_e = t;
    sa = step(sa, r, s, f, b, t, 32'h0000_0000, 65535);
    sb = step(sb, r, s, f, b, t, 32'hFFFF_FFF8, 15);
    qa.push_back(sa);
    qb.push_back(sb);
  endtask

  // Monitor: after each edge, compare the DUT against the oldest queued expectation.
  always @(posedge clk) begin
    ms_t ea;
    ms_t eb;
    #1;
    if (qa.size() > 0 && qb.size() > 0) begin
      ea = qa.pop_front();
      eb = qb.pop_front();
      chk("a_pc_f",       pc_f_a,                 ea.pc);
      chk("a_imem_addr",  imem_addr_a,            ea.pc);
      chk("a_instr_d",    instr_d_a,              ea.instr);
      chk("a_pc_d",       pc_d_a,                 ea.pcd);
      chk("a_pc_plus4_d", pc_plus4_d_a,           ea.pcp4);
      chk("a_valid_d",    {31'd0, valid_d_a},     {31'd0, ea.valid});
      chk("a_fetch_cnt",  {16'd0, fetch_count_a}, ea.fc);
      chk("a_bubble_cnt", {16'd0, bubble_count_a}, ea.bc);
      chk("b_pc_f",       pc_f_b,                 eb.pc);
      chk("b_instr_d",    instr_d_b,              eb.instr);
      chk("b_pc_plus4_d", pc_plus4_d_b,           eb.pcp4);
      chk("b_valid_d",    {31'd0, valid_d_b},     {31'd0, eb.valid});
      chk("b_fetch_cnt",  {28'd0, fetch_count_b}, eb.fc);
      chk("b_bubble_cnt", {28'd0, bubble_count_b}, eb.bc);
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    checks = 0;
    failures = 0;
    sa = '{pc: 32'h0, instr: 32'h0, pcd: 32'h0, pcp4: 32'h0, valid: 1'b0, fc: 0, bc: 0};
    sb = sa;
    reset = 1'b0; stall_f = 1'b0; flush_d = 1'b0; branch_taken_e = 1'b0;
    branch_target_e = 32'h0;

    // Reset two cycles, then sequential fetch 0,4,8,C,10.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    // Stall three cycles at 0x10, then resume and advance to 0x20.
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    // Branch to unaligned 0x103 from 0x20.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0103);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    // Stall with branch, then stall with flush.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0200);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    // Long unbroken run: saturates the 4-bit counters.
    repeat (20) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    // Reset asserted mid-stream during a stall.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    // PC wrap on the default instance.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF9);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

    // Randomized hazards, redirects and occasional resets.
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), $urandom());
    end

    @(posedge clk);
    #3;
    chk("queue_drain", qa.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
